// File: rtl/zpc_video_top.sv
// ZPC board top: 25 MHz pixel enable from the 50 MHz board clock, 640x480@60 VGA timing,
// a 3-bit animated tile pattern and a frame-driven heartbeat LED.
module zpc_video_top #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int LED_FRAMES = 30
) (
  input  logic clk_50mhz,
  input  logic rst_n,
  output logic vga_red,
  output logic vga_green,
  output logic vga_blue,
  output logic vga_hsync,
  output logic vga_vsync,
  output logic led,
  output logic clk
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC);

  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  localparam int              LED_W    = (LED_FRAMES > 1) ? $clog2(LED_FRAMES) : 1;
  localparam logic [LED_W-1:0] LED_LAST = LED_W'(LED_FRAMES - 1);

  function automatic logic in_window(input logic [9:0] pos, input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (pos >= lo) && (pos < hi);
  endfunction

  // Colour wraps naturally in 3 bits, which is the required mod-8 sum.
  function automatic logic [2:0] tile_color(input logic [2:0] tile_x, input logic [2:0] tile_y,
                                            input logic [2:0] phase);
    return tile_x + tile_y + phase;
  endfunction

  logic             clk_r;
  logic [9:0]       h_r;
  logic [9:0]       v_r;
  logic [7:0]       frame_r;
  logic [LED_W-1:0] led_cnt_r;
  logic             led_r;
  logic [2:0]       rgb_r;
  logic             hsync_r;
  logic             vsync_r;

  logic             pix_ce_s;
  logic             h_wrap_s;
  logic             v_wrap_s;
  logic             frame_end_s;
  logic             display_s;
  logic [9:0]       h_next_s;
  logic [9:0]       v_next_s;
  logic [7:0]       frame_next_s;
  logic [2:0]       rgb_next_s;
  logic             hsync_next_s;
  logic             vsync_next_s;

  always_comb begin
    pix_ce_s     = clk_r;
    h_wrap_s     = (h_r == H_LAST);
    v_wrap_s     = (v_r == V_LAST);
    frame_end_s  = h_wrap_s && v_wrap_s;
    display_s    = (h_r < H_VIS_END) && (v_r < V_VIS_END);
    h_next_s     = h_r;
    v_next_s     = v_r;
    frame_next_s = frame_r;
    rgb_next_s   = 3'b000;

    if (h_wrap_s) begin
      h_next_s = 10'd0;
    end else begin
      h_next_s = h_r + 10'd1;
    end

    if (h_wrap_s) begin
      if (v_wrap_s) begin
        v_next_s = 10'd0;
      end else begin
        v_next_s = v_r + 10'd1;
      end
    end else begin
      v_next_s = v_r;
    end

    if (frame_end_s) begin
      frame_next_s = frame_r + 8'd1;
    end else begin
      frame_next_s = frame_r;
    end

    if (display_s) begin
      rgb_next_s = tile_color(h_r[8:6], v_r[8:6], frame_r[5:3]);
    end else begin
      rgb_next_s = 3'b000;
    end

    hsync_next_s = ~in_window(h_r, H_SYNC_START, H_SYNC_END);
    vsync_next_s = ~in_window(v_r, V_SYNC_START, V_SYNC_END);
  end

  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      clk_r <= 1'b0;
    end else begin
      clk_r <= ~clk_r;
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      h_r     <= 10'd0;
      v_r     <= 10'd0;
      frame_r <= 8'd0;
    end else if (pix_ce_s) begin
      h_r     <= h_next_s;
      v_r     <= v_next_s;
      frame_r <= frame_next_s;
    end
  end

  // Heartbeat toggles once every LED_FRAMES completed frames.
  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      led_cnt_r <= '0;
      led_r     <= 1'b0;
    end else if (pix_ce_s && frame_end_s) begin
      if (led_cnt_r == LED_LAST) begin
        led_cnt_r <= '0;
        led_r     <= ~led_r;
      end else begin
        led_cnt_r <= led_cnt_r + LED_W'(1);
      end
    end
  end

  // Outputs are built from the pre-increment position, so they trail the counters by one pixel.
  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      rgb_r   <= 3'b000;
      hsync_r <= 1'b1;
      vsync_r <= 1'b1;
    end else if (pix_ce_s) begin
      rgb_r   <= rgb_next_s;
      hsync_r <= hsync_next_s;
      vsync_r <= vsync_next_s;
    end
  end

  assign vga_red   = rgb_r[2];
  assign vga_green = rgb_r[1];
  assign vga_blue  = rgb_r[0];
  assign vga_hsync = hsync_r;
  assign vga_vsync = vsync_r;
  assign led       = led_r;
  assign clk       = clk_r;

endmodule

// File: tb/tb_zpc_video_top.sv
// Scoreboard bench for zpc_video_top using a shrunken raster so that tiles, frame phase
// and the LED all change within a short run.
module tb_zpc_video_top;

  localparam int HV = 68, HF = 1, HS = 2, HB = 1;
  localparam int VV = 65, VF = 1, VS = 1, VB = 1;
  localparam int LF = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FR = HT * VT;

  logic clk_50mhz = 1'b0;
  logic rst_n = 1'b0;
  logic vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, led, clk;

  int compared = 0;
  int mismatched = 0;
  logic [6:0] sb_q[$];

  zpc_video_top #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .LED_FRAMES(LF)
  ) dut (
    .clk_50mhz(clk_50mhz),
    .rst_n(rst_n),
    .vga_red(vga_red),
    .vga_green(vga_green),
    .vga_blue(vga_blue),
    .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync),
    .led(led),
    .clk(clk)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  // Expected {clk, r, g, b, hsync, vsync, led} after the edge that emits pixel n of the run.
  function automatic logic [6:0] model(input int n);
    int h, v, f, c;
    logic hs, vs, ld;
    h  = n % HT;
    v  = (n / HT) % VT;
    f  = (n / FR) % 256;
    c  = ((h / 64) + (v / 64) + ((f / 8) % 8)) % 8;
    if (!(h < HV && v < VV)) c = 0;
    hs = !(h >= HV + HF && h < HV + HF + HS);
    vs = !(v >= VV + VF && v < VV + VF + VS);
    ld = ((((n + 1) / FR) / LF) % 2) == 1;
    return {1'b0, 3'(c), hs, vs, ld};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_pixels(input int count);
    logic [6:0] exp;
    logic [2:0] rgb;
    for (int n = 0; n < count; n++) begin
      sb_q.push_back(model(n));
      @(posedge clk_50mhz);
      @(negedge clk_50mhz);
      check("clk_high", 32'(clk), 32'd1);
      if (n == 0)
        check("pre_first_pixel", 32'({vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, led}),
              32'b000110);
      @(posedge clk_50mhz);
      @(negedge clk_50mhz);
      if (sb_q.size() == 0) begin
        check("sb_empty", 32'd0, 32'd1);
      end else begin
        exp = sb_q.pop_front();
        check("pixel", 32'({clk, vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, led}),
              32'(exp));
      end
      rgb = {vga_red, vga_green, vga_blue};
      case (n)
        0:              check("rgb_0_0_f0", 32'(rgb), 32'b000);
        64:             check("rgb_64_0_f0", 32'(rgb), 32'b001);
        64 * HT:        check("rgb_0_64_f0", 32'(rgb), 32'b001);
        64 * HT + 64:   check("rgb_64_64_f0", 32'(rgb), 32'b010);
        HV:             check("rgb_blank_h", 32'(rgb), 32'b000);
        VV * HT:        check("rgb_blank_v", 32'(rgb), 32'b000);
        HV + HF:        check("hsync_first_low", 32'(vga_hsync), 32'd0);
        HV + HF + HS:   check("hsync_back_high", 32'(vga_hsync), 32'd1);
        (VV + VF) * HT: check("vsync_first_low", 32'(vga_vsync), 32'd0);
        3 * FR - 2:     check("led_before_rise", 32'(led), 32'd0);
        3 * FR - 1:     check("led_rise", 32'(led), 32'd1);
        6 * FR - 1:     check("led_fall", 32'(led), 32'd0);
        8 * FR:         check("rgb_0_0_f8", 32'(rgb), 32'b001);
        8 * FR + 64:    check("rgb_64_0_f8", 32'(rgb), 32'b010);
        default: ;
      endcase
    end
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    repeat (4) @(posedge clk_50mhz);
    @(negedge clk_50mhz);
    check("reset_state", 32'({clk, vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, led}),
          32'b0_000_11_0);
    rst_n = 1'b1;

    run_pixels(8 * FR + 30 * HT + 30);

    // One-cycle reset mid-frame, then time the first hsync fall from the release.
    rst_n = 1'b0;
    @(posedge clk_50mhz);
    @(negedge clk_50mhz);
    check("midframe_reset", 32'({clk, vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, led}),
          32'b0_000_11_0);
    rst_n = 1'b1;
    c = 0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk_50mhz);
      @(negedge clk_50mhz);
      c = k;
      if (!vga_hsync) break;
    end
    // First pixel edge is the second edge after release; the output register adds one more.
    check("hsync_fall_after_reset", 32'(c), 32'(2 * (HV + HF) + 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
